// File: rtl/apb_cfg_regfile.sv
// APB3 configuration register file: CTRL/STATUS plus NUM_CFG generic words, programmable wait states.
// Optional build macro CFG_SHADOW_EN stages cfg writes in shadow registers that load into cfg_out on start.
module apb_cfg_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CFG = 12,
    parameter int WAIT_STATES = 0,
    parameter logic [NUM_CFG*DATA_WIDTH-1:0] CFG_RESET_VAL = '0
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [ADDR_WIDTH-1:0]         PADDR,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [DATA_WIDTH-1:0]         PWDATA,
    output logic [DATA_WIDTH-1:0]         PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    output logic                          start_tpu,
    output logic                          busy,
    output logic                          irq,
    output logic [NUM_CFG*DATA_WIDTH-1:0] cfg_out,
    input  logic                          done_tpu
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int CNT_W = 4;

    // Bus handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0); PREADY is
    // raised for exactly one access cycle, WAIT_STATES+1 cycles later, and a write is
    // committed at the end of that cycle only if PSEL, PENABLE and PWRITE are still high.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic pready_q, pready_d;
    logic pslverr_q, pslverr_d;

    logic start_q, start_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    logic [DATA_WIDTH-1:0] cfg_out_q [NUM_CFG];
    logic [DATA_WIDTH-1:0] cfg_out_d [NUM_CFG];
    logic [DATA_WIDTH-1:0] cfg_rd [NUM_CFG];
`ifdef CFG_SHADOW_EN
    logic [DATA_WIDTH-1:0] shadow_q [NUM_CFG];
    logic [DATA_WIDTH-1:0] shadow_d [NUM_CFG];
`endif

    logic [IDX_W-1:0] widx;
    logic addr_ok;
    logic enter_resp;
    logic commit;
    logic wr_ctrl;
    logic wr_status;
    logic wr_cfg;
    logic done_evt;
    logic [DATA_WIDTH-1:0] rd_data;

    assign widx    = PADDR[ADDR_WIDTH-1:2];
    assign addr_ok = (32'(widx) < 32'(NUM_CFG + 2));

    assign commit    = (state_q == S_RESP) && PSEL && PENABLE && PWRITE && addr_ok;
    assign wr_ctrl   = commit && (widx == IDX_W'(0));
    assign wr_status = commit && (widx == IDX_W'(1));
    assign wr_cfg    = commit && (32'(widx) >= 32'd2);
    assign done_evt  = done_tpu && busy_q;

`ifdef CFG_SHADOW_EN
    always_comb begin
        cfg_rd = shadow_q;
    end
`else
    always_comb begin
        cfg_rd = cfg_out_q;
    end
`endif

    // Read value of the currently addressed word; illegal addresses are zeroed later.
    always_comb begin
        rd_data = '0;
        if (widx == IDX_W'(0)) begin
            rd_data[1] = irq_en_q;
        end else if (widx == IDX_W'(1)) begin
            rd_data[0] = busy_q;
            rd_data[1] = done_q;
        end
        for (int k = 0; k < NUM_CFG; k++) begin
            if (widx == IDX_W'(k + 2)) begin
                rd_data = cfg_rd[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        prdata_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    if (WAIT_STATES == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Response fields are latched on the edge entering RESP so they are stable while PREADY=1.
        if (enter_resp) begin
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = !addr_ok;
            prdata_d  = addr_ok ? rd_data : '0;
        end
    end

    always_comb begin
        start_d  = wr_ctrl && PWDATA[0] && !busy_q;
        irq_en_d = wr_ctrl ? PWDATA[1] : irq_en_q;
        busy_d   = busy_q;
        if (done_evt) begin
            busy_d = 1'b0;
        end
        if (start_d) begin
            busy_d = 1'b1;
        end
        // A completion arriving with a W1C clear must not be lost, so the set is applied last.
        done_d = done_q;
        if (wr_status && PWDATA[1]) begin
            done_d = 1'b0;
        end
        if (done_evt) begin
            done_d = 1'b1;
        end
        irq_d = done_q && irq_en_q;
    end

    always_comb begin
        cfg_out_d = cfg_out_q;
`ifdef CFG_SHADOW_EN
        shadow_d = shadow_q;
        for (int k = 0; k < NUM_CFG; k++) begin
            if (wr_cfg && (widx == IDX_W'(k + 2))) begin
                shadow_d[k] = PWDATA;
            end
        end
        // Load uses the pre-edge shadow image, so a same-edge cfg write waits for the next start.
        if (start_d) begin
            cfg_out_d = shadow_q;
        end
`else
        for (int k = 0; k < NUM_CFG; k++) begin
            if (wr_cfg && (widx == IDX_W'(k + 2))) begin
                cfg_out_d[k] = PWDATA;
            end
        end
`endif
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            for (int k = 0; k < NUM_CFG; k++) begin
                cfg_out_q[k] <= CFG_RESET_VAL[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef CFG_SHADOW_EN
                shadow_q[k]  <= CFG_RESET_VAL[k*DATA_WIDTH +: DATA_WIDTH];
`endif
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            cfg_out_q <= cfg_out_d;
`ifdef CFG_SHADOW_EN
            shadow_q  <= shadow_d;
`endif
        end
    end

    assign PRDATA    = prdata_q;
    assign PREADY    = pready_q;
    assign PSLVERR   = pslverr_q;
    assign start_tpu = start_q;
    assign busy      = busy_q;
    assign irq       = irq_q;

    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_flat
        assign cfg_out[k*DATA_WIDTH +: DATA_WIDTH] = cfg_out_q[k];
    end

endmodule

// File: tb/tb_apb_cfg_regfile.sv
// Bench for apb_cfg_regfile: APB driver tasks, queue scoreboard with a PREADY-triggered monitor,
// and a word-level reference model of the register map (shadow behaviour follows CFG_SHADOW_EN).
module tb_apb_cfg_regfile;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NC = 12;
    localparam int WS = 2;

    function automatic logic [NC*DW-1:0] mk_rst();
        logic [NC*DW-1:0] r;
        for (int k = 0; k < NC; k++) begin
            r[k*DW +: DW] = 32'h1000_0000 + 32'(k) * 32'h111;
        end
        return r;
    endfunction

    localparam logic [NC*DW-1:0] RST_IMG = mk_rst();

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] paddr = '0;
    logic psel = 1'b0;
    logic penable = 1'b0;
    logic pwrite = 1'b0;
    logic [DW-1:0] pwdata = '0;
    logic [DW-1:0] prdata;
    logic pready;
    logic pslverr;
    logic start_tpu;
    logic busy;
    logic irq;
    logic [NC*DW-1:0] cfg_out;
    logic done_tpu = 1'b0;

    apb_cfg_regfile #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CFG(NC), .WAIT_STATES(WS), .CFG_RESET_VAL(RST_IMG)
    ) dut (
        .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
        .PSLVERR(pslverr), .start_tpu(start_tpu), .busy(busy), .irq(irq),
        .cfg_out(cfg_out), .done_tpu(done_tpu)
    );

    always #5 clk = ~clk;

    // Reference model: rd_m is what a read returns, out_m is what cfg_out shows.
    logic [DW-1:0] rd_m [NC];
    logic [DW-1:0] out_m [NC];
    bit irq_en_m, busy_m, done_m;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW+1:0] exp_q[$];  // {check_data, pslverr, prdata}

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC*DW-1:0] flat_out();
        logic [NC*DW-1:0] r;
        for (int k = 0; k < NC; k++) r[k*DW +: DW] = out_m[k];
        return r;
    endfunction

    function automatic logic [DW-1:0] model_read(input int w);
        if (w == 0) return {30'b0, irq_en_m, 1'b0};
        if (w == 1) return {30'b0, done_m, busy_m};
        if (w < NC + 2) return rd_m[w-2];
        return '0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            rd_m[k]  = 32'h1000_0000 + 32'(k) * 32'h111;
            out_m[k] = rd_m[k];
        end
        irq_en_m = 0; busy_m = 0; done_m = 0;
    endtask

    task automatic model_write(input int w, input logic [DW-1:0] d, input bit done_same, output bit pulse);
        bit start_ok;
        pulse = 0;
        start_ok = (w == 0) && d[0] && !busy_m;
        if (w == 0) irq_en_m = d[1];
        if (w == 1 && d[1]) done_m = 0;
        if (w >= 2 && w < NC + 2) begin
            rd_m[w-2] = d;
`ifndef CFG_SHADOW_EN
            out_m[w-2] = d;
`endif
        end
        if (done_same && busy_m) begin
            busy_m = 0;
            done_m = 1;
        end
        if (start_ok) begin
            busy_m = 1;
            pulse = 1;
`ifdef CFG_SHADOW_EN
            for (int k = 0; k < NC; k++) out_m[k] = rd_m[k];
`endif
        end
    endtask

    // Monitor: every PREADY cycle consumes one expected response.
    always @(negedge clk) begin
        if (!rst && pready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pready: got PREADY=1 expected no response at %0t", $time);
            end else begin
                logic [DW+1:0] e;
                e = exp_q.pop_front();
                check("pslverr", DW'(pslverr), DW'(e[DW]));
                if (e[DW+1]) check("prdata", prdata, e[DW-1:0]);
            end
        end
    end

    // Called at #1 after a clock edge; returns at #1 after the commit edge.
    task automatic apb_xfer(input bit wr, input int w, input logic [DW-1:0] d, input bit done_same);
        int lat;
        bit err, pulse;
        err = (w >= NC + 2);
        exp_q.push_back({!wr, err, err ? 32'h0 : model_read(w)});
        psel = 1; penable = 0; pwrite = wr; pwdata = d;
        paddr = AW'(w * 4 + int'($urandom_range(0, 3)));
        @(posedge clk); #1;
        penable = 1;
        lat = 1;
        while (pready !== 1'b1 && lat <= 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", DW'(lat), DW'(WS + 1));
        if (lat > 20) begin
            psel = 0; penable = 0;
            return;
        end
        if (done_same) done_tpu = 1;
        @(posedge clk); #1;
        done_tpu = 0; psel = 0; penable = 0;
        pulse = 0;
        if (wr) model_write(w, d, done_same, pulse);
        check("start_pulse", DW'(start_tpu), DW'(pulse));
        check("busy", DW'(busy), DW'(busy_m));
        check("cfg_out", cfg_out[DW-1:0], out_m[0]);
        n_cmp++;
        if (cfg_out !== flat_out()) begin
            n_err++;
            $display("FAIL cfg_out_all: got %h expected %h", cfg_out, flat_out());
        end
        if (pulse) begin
            @(posedge clk); #1;
            check("start_one_cycle", DW'(start_tpu), 32'd0);
        end
    endtask

    task automatic pulse_done();
        done_tpu = 1;
        @(posedge clk); #1;
        done_tpu = 0;
        if (busy_m) begin
            busy_m = 0;
            done_m = 1;
        end
        check("busy_after_done", DW'(busy), DW'(busy_m));
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
        check("irq", DW'(irq), DW'(done_m & irq_en_m));
        check("busy_idle", DW'(busy), DW'(busy_m));
        check("start_idle", DW'(start_tpu), 32'd0);
    endtask

    // Drops PSEL while the slave is still counting wait states.
    task automatic abort_xfer(input int w, input logic [DW-1:0] d);
        bit seen;
        psel = 1; penable = 0; pwrite = 1; pwdata = d; paddr = AW'(w * 4);
        @(posedge clk); #1;
        penable = 1;
        seen = pready;
        @(posedge clk); #1;
        seen |= pready;
        psel = 0; penable = 0;
        repeat (6) begin
            @(posedge clk); #1;
            seen |= pready;
        end
        check("abort_no_pready", DW'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_prdata", prdata, 32'd0);
        check("rst_pready", DW'(pready), 32'd0);
        check("rst_pslverr", DW'(pslverr), 32'd0);
        check("rst_start", DW'(start_tpu), 32'd0);
        check("rst_busy", DW'(busy), 32'd0);
        check("rst_irq", DW'(irq), 32'd0);
        n_cmp++;
        if (cfg_out !== RST_IMG) begin
            n_err++;
            $display("FAIL rst_cfg_out: got %h expected %h", cfg_out, RST_IMG);
        end
        rst = 0;

        for (int w = 0; w < NC + 2; w++) apb_xfer(0, w, '0, 0);

        apb_xfer(1, 2, 32'hA5A5_0001, 0);
        apb_xfer(0, 2, '0, 0);

        apb_xfer(0, NC + 2, '0, 0);
        apb_xfer(1, NC + 2, 32'hFFFF_FFFF, 0);
        apb_xfer(0, 63, '0, 0);
        for (int w = 0; w < NC + 2; w++) apb_xfer(0, w, '0, 0);

        apb_xfer(1, 0, 32'h3, 0);
        apb_xfer(1, 0, 32'h3, 0);
        apb_xfer(0, 1, '0, 0);
        pulse_done();
        idle_check(2);
        apb_xfer(0, 1, '0, 0);
        apb_xfer(1, 1, 32'h2, 0);
        idle_check(2);

        apb_xfer(1, 0, 32'h3, 0);
        apb_xfer(1, 1, 32'h2, 1);
        apb_xfer(0, 1, '0, 0);
        idle_check(2);

        apb_xfer(1, 2, 32'h55, 0);
        apb_xfer(0, 2, '0, 0);
        apb_xfer(1, 1, 32'h2, 0);
        apb_xfer(1, 0, 32'h1, 0);
        pulse_done();
        idle_check(2);

        abort_xfer(3, 32'hDEAD_BEEF);
        apb_xfer(0, 3, '0, 0);

        for (int i = 0; i < 300; i++) begin
            int w;
            bit wr, ds;
            logic [DW-1:0] d;
            w  = ($urandom_range(0, 99) < 90) ? int'($urandom_range(0, NC + 1)) : int'($urandom_range(NC + 2, 63));
            wr = 1'($urandom_range(0, 1));
            d  = $urandom();
            ds = wr && ($urandom_range(0, 9) == 0);
            apb_xfer(wr, w, d, ds);
            if ($urandom_range(0, 5) == 0) pulse_done();
            if ($urandom_range(0, 7) == 0) idle_check(2);
        end
        for (int w = 0; w < NC + 2; w++) apb_xfer(0, w, '0, 0);

        repeat (4) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
